dff_univ_reg: RTL and testbench

- Parametrised successor to the single-bit DFF/DFFSR cells: a WIDTH-bit register with clock enable and eight synchronous modes.
- Modes: hold, parallel load, shift, rotate, count up/down.
- Sits in the cell library as a standard macro cell for timing-annotated gate-level simulation and for Qflow test designs (shift chains, counters, pipeline registers).
- Async active-high reset loads a parametrised value.

---
 rtl/dff_univ_reg.sv | 107 ++++++++++
 tb/tb_dff_univ_reg.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dff_univ_reg.sv
// ---------------------------------------------------------------------------
// dff_univ_reg
//   WIDTH-bit universal register macro cell. It has a clock enable and eight
//   synchronous modes: hold, load, shift right/left, rotate right/left, and
//   count up/down. An asynchronous active-high reset loads RESET_VAL.
//
// Ports
//   C    in   1      clock, rising edge
//   R    in   1      asynchronous reset, active high (Q <= RESET_VAL)
//   E    in   1      clock enable; Q updates only when E=1 at posedge C
//   MODE in   3      000 hold, 001 load, 010 shr, 011 shl,
//                    100 ror, 101 rol, 110 count up, 111 count down
//   D    in   WIDTH  parallel load data
//   SI   in   1      serial input for the shift modes
//   Q    out  WIDTH  register contents
//   SOR  out  1      Q[0]       (combinational)
//   SOL  out  1      Q[WIDTH-1] (combinational)
//   TC   out  1      terminal count (combinational, independent of E)
//
// Build option
//   CMOS_TIMING_EN : when defined, adds a specify block with clock-to-Q
//                    delays TPD, setup/hold checks (TSU/TH) and a reset
//                    pulse-width check. Cycle behaviour is identical.
// ---------------------------------------------------------------------------
module dff_univ_reg #(
  parameter int                WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}},
  parameter real               TPD       = 2.5,
  parameter real               TSU       = 1.3,
  parameter real               TH        = 1.0
) (
  input  logic             C,
  input  logic             R,
  input  logic             E,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SI,
  output logic [WIDTH-1:0] Q,
  output logic             SOR,
  output logic             SOL,
  output logic             TC
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_SHL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_UP   = 3'b110;
  localparam logic [2:0] MODE_DOWN = 3'b111;

  logic [WIDTH-1:0] r_q;
  logic             w_all_ones;
  logic             w_all_zero;

  // One register process for every mode. An unknown MODE drives Q to X,
  // so that simulation shows the problem. Synthesis treats it as don't-care.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      r_q <= RESET_VAL;
    end else if (E) begin
      case (MODE)
        MODE_HOLD: r_q <= r_q;
        MODE_LOAD: r_q <= D;
        MODE_SHR:  r_q <= {SI, r_q[WIDTH-1:1]};
        MODE_SHL:  r_q <= {r_q[WIDTH-2:0], SI};
        MODE_ROR:  r_q <= {r_q[0], r_q[WIDTH-1:1]};
        MODE_ROL:  r_q <= {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        MODE_UP:   r_q <= r_q + WIDTH'(1);
        MODE_DOWN: r_q <= r_q - WIDTH'(1);
        default:   r_q <= {WIDTH{1'bx}};
      endcase
    end
  end

  assign w_all_ones = &r_q;
  assign w_all_zero = ~|r_q;

  assign Q   = r_q;
  assign SOR = r_q[0];
  assign SOL = r_q[WIDTH-1];
  // TC ignores E. A cascaded stage can then use (E & TC) as its enable.
  assign TC  = ((MODE == MODE_UP) && w_all_ones) ||
               ((MODE == MODE_DOWN) && w_all_zero);

`ifdef CMOS_TIMING_EN
  logic r_notifier;

  specify
    (C *> Q) = (TPD, TPD);
    $setup(D,    posedge C, TSU, r_notifier);
    $setup(SI,   posedge C, TSU, r_notifier);
    $setup(E,    posedge C, TSU, r_notifier);
    $setup(MODE, posedge C, TSU, r_notifier);
    $hold(posedge C, D,    TH, r_notifier);
    $hold(posedge C, SI,   TH, r_notifier);
    $hold(posedge C, E,    TH, r_notifier);
    $hold(posedge C, MODE, TH, r_notifier);
    $width(posedge R, TPD, 0, r_notifier);
  endspecify
`else
  // The zero-delay model does not use the timing parameters.
  localparam real unused_timing = TPD + TSU + TH;
`endif

endmodule

// File: tb/tb_dff_univ_reg.sv
// ---------------------------------------------------------------------------
// tb_dff_univ_reg
//   Directed-vector bench for dff_univ_reg (WIDTH=8, RESET_VAL=8'hA5).
//   One instance covers reset, enable, every mode and the TC boundaries.
//   A second pair of instances forms a cascaded 16-bit counter.
// ---------------------------------------------------------------------------
module tb_dff_univ_reg;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;

  // clock / reset
  logic c = 1'b0;
  logic r = 1'b0;
  always #5 c = ~c;

  // main instance
  logic         e    = 1'b0;
  logic [2:0]   mode = 3'b000;
  logic [W-1:0] d    = '0;
  logic         si   = 1'b0;
  logic [W-1:0] q;
  logic         sor, sol, tc;

  dff_univ_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .C(c), .R(r), .E(e), .MODE(mode), .D(d), .SI(si),
    .Q(q), .SOR(sor), .SOL(sol), .TC(tc)
  );

  // cascaded pair: the high stage is enabled by (lo_e & lo_tc), or by lo_e
  // directly during the initial load.
  logic         lo_e     = 1'b0;
  logic         c_load   = 1'b0;
  logic [2:0]   c_mode   = 3'b000;
  logic [W-1:0] c_d      = '0;
  logic [W-1:0] lo_q, hi_q;
  logic         lo_sor, lo_sol, lo_tc, hi_sor, hi_sol, hi_tc;
  logic         hi_e;

  assign hi_e = c_load ? lo_e : (lo_e & lo_tc);

  dff_univ_reg #(.WIDTH(W), .RESET_VAL(RV)) u_lo (
    .C(c), .R(r), .E(lo_e), .MODE(c_mode), .D(c_d), .SI(1'b0),
    .Q(lo_q), .SOR(lo_sor), .SOL(lo_sol), .TC(lo_tc)
  );

  dff_univ_reg #(.WIDTH(W), .RESET_VAL(RV)) u_hi (
    .C(c), .R(r), .E(hi_e), .MODE(c_mode), .D(c_d), .SI(1'b0),
    .Q(hi_q), .SOR(hi_sor), .SOL(hi_sol), .TC(hi_tc)
  );

  // scoreboard
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // The next posedge samples the inputs. Outputs are observed 1 ns later.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge c);
      #1;
    end
  endtask

  task automatic load(input logic [W-1:0] val);
    e = 1'b1; mode = 3'b001; d = val;
    tick(1);
  endtask

  initial begin
    // async reset while C is low and idle
    #3 r = 1'b1;
    #1;
    check("reset_async_q", q, RV);
    check("reset_sor_sol", {6'd0, sol, sor}, {6'd0, RV[W-1], RV[0]});
    tick(1);
    check("reset_held_q", q, RV);
    r = 1'b0;

    // E=0 holds for 3 clocks regardless of mode
    e = 1'b0; mode = 3'b001; d = 8'h12;
    tick(3);
    check("enable_low_hold", q, RV);

    // load, then shift right twice with SI=1
    load(8'h3C);
    check("load_3c", q, 8'h3C);
    mode = 3'b010; si = 1'b1;
    tick(1);
    check("shr_1", q, 8'h9E);
    tick(1);
    check("shr_2", q, 8'hCF);
    check("shr_sor_sol", {6'd0, sol, sor}, 8'h03);

    // rotate right once, then rotate left twice
    load(8'h81);
    mode = 3'b100; si = 1'b0;
    tick(1);
    check("ror_1", q, 8'hC0);
    mode = 3'b101; si = 1'b1;   // SI is ignored when rotating
    tick(2);
    check("rol_2", q, 8'h03);

    // shift left with SI=0, then hold
    load(8'h55);
    mode = 3'b011; si = 1'b0;
    tick(1);
    check("shl_1", q, 8'hAA);
    mode = 3'b000;
    tick(2);
    check("mode_hold", q, 8'hAA);

    // count up through the all-ones wrap, then count down
    load(8'hFE);
    mode = 3'b110;
    #1;
    check("tc_up_fe", {7'd0, tc}, 8'd0);
    tick(1);
    check("up_ff", q, 8'hFF);
    check("tc_up_ff", {7'd0, tc}, 8'd1);
    tick(1);
    check("up_wrap_00", q, 8'h00);
    check("tc_up_00", {7'd0, tc}, 8'd0);
    mode = 3'b111;
    #1;
    check("tc_down_00", {7'd0, tc}, 8'd1);
    tick(1);
    check("down_wrap_ff", q, 8'hFF);
    check("tc_down_ff", {7'd0, tc}, 8'd0);

    // TC does not depend on E
    e = 1'b0; mode = 3'b110;
    tick(1);
    check("e0_hold_ff", q, 8'hFF);
    check("tc_e0", {7'd0, tc}, 8'd1);

    // reset in the middle of counting
    e = 1'b1; mode = 3'b111;
    tick(1);
    check("down_fe", q, 8'hFE);
    #2 r = 1'b1;
    #1;
    check("reset_mid_count", q, RV);
    tick(1);
    r = 1'b0;
    check("reset_mid_held", q, RV);

    // cascaded 16-bit counter: load both halves with 0, then count 256
    c_load = 1'b1; lo_e = 1'b1; c_mode = 3'b001; c_d = 8'h00;
    tick(1);
    check("casc_load_lo", lo_q, 8'h00);
    check("casc_load_hi", hi_q, 8'h00);
    c_load = 1'b0; c_mode = 3'b110;
    tick(255);
    check("casc_255_lo", lo_q, 8'hFF);
    check("casc_255_hi", hi_q, 8'h00);
    tick(1);
    check("casc_256_lo", lo_q, 8'h00);
    check("casc_256_hi", hi_q, 8'h01);
    tick(5);
    #2 r = 1'b1;
    #1;
    check("casc_reset_lo", lo_q, RV);
    check("casc_reset_hi", hi_q, RV);
    tick(1);
    r = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
